pila_subrutinas: RTL and testbench
==================================

# pila_subrutinas

Return-address stack for the monocycle CPU. It sits directly downstream of the control unit: it consumes the `push`/`pop` strobes and stores or returns program-counter values for subroutine call/return. The top-of-stack value is read combinationally, so the next-PC mux (selected by `s_stack`) can use it in the same cycle as the `pop`. All pointer and flag updates happen on the rising clock edge.

## Interface
- `AW`, 10: width of a stored address (matches PC width).
- `DEPTH`, 8: number of entries; must be a power of two, at least 2.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high. Clears the pointer and the flags.
- `push`  in  1: store `din` on top of the stack (from the control unit).
- `pop`  in  1: remove the top entry (from the control unit).
- `din`  in  AW: return address to store (PC+1 from the fetch stage).
- `dout`  out  AW: current top entry; combinational.
- `empty`  out  1: stack holds 0 entries.
- `full`  out  1: stack holds DEPTH entries.
- `count`  out  $clog2(DEPTH)+1: number of valid entries.
- `ovf`  out  1: sticky flag; a push was attempted while full.
- `unf`  out  1: sticky flag; a pop was attempted while empty.

## Operation
- Storage: `DEPTH` × `AW` register array. The array is not reset.
- State:
  - Pointer `sp` ranges 0..DEPTH and equals `count`; it points at the next free slot.
  - Top entry is `mem[sp-1]`.
- Derived outputs:
  - `dout` = `mem[sp-1]` when `sp`>0, otherwise all-zero.
  - `empty` = (`sp`==0); `full` = (`sp`==DEPTH).
- Per-edge actions, evaluated on `push`, `pop`, `full`, `empty` before the edge:
  - Push only, not full: `mem[sp]`<=`din`; `sp`<=`sp`+1.
  - Push only, full: no write, `sp` unchanged, `ovf`<=1.
  - Pop only, not empty: `sp`<=`sp`-1. Entry contents are left in place.
  - Pop only, empty: `sp` unchanged, `unf`<=1.
  - Push and pop, not empty: replace the top. `mem[sp-1]`<=`din`; `sp` unchanged.
  - Push and pop, empty: treated as push only. `mem[0]`<=`din`; `sp`<=1; `unf` not set.
  - Neither: hold.
- `ovf` and `unf` stay set until `reset`. They never block later legal operations.
- Width rules:
  - `sp` is `$clog2(DEPTH)+1` bits wide and never wraps.
  - Saturation at 0 and at DEPTH is enforced by the rules above, not by modular arithmetic.

## Timing
- Reset values, applied asynchronously:
  - `sp`=0, `count`=0, `empty`=1, `full`=0, `ovf`=0, `unf`=0, `dout`=0.
- Push latency: the pushed value appears on `dout` after the edge that samples `push` (1 cycle).
- Pop latency:
  - `dout` shows the entry being popped during the pop cycle, with 0 cycles latency. This is the return PC the next-PC mux uses.
  - After the edge, `dout` shows the new top, or 0 if the stack is now empty.
- `count`, `empty`, `full`, `ovf` and `unf` are registered or derived from registers. They change only on a clock edge or on reset.
- Reset asserted mid-operation:
  - All state clears immediately, regardless of `clk`.
  - A push or pop sampled while `reset`=1 has no effect.
- The inputs carry no handshake. Each cycle with a strobe high is one operation; a held strobe repeats every cycle.

## Test plan
- Reset: assert `reset` between edges. `count`=0, `empty`=1, `dout`=0 and both flags are 0 immediately, without waiting for a clock.
- LIFO order: push 0x010, 0x020, 0x3FF on consecutive cycles, so `count`=3 and `dout`=0x3FF. Then pop ×3:
  - `dout` during the pops is 0x3FF, 0x020, 0x010 in that order.
  - Finally `empty`=1 and `dout`=0.
- Full/overflow (DEPTH=8): push 0x001..0x008, so `full`=1. Push 0x0AA:
  - `ovf`=1, `count`=8, `dout`=0x008.
  - 8 pops then return 0x008..0x001.
- Underflow: on an empty stack, pop. `unf`=1, `count`=0. A following push of 0x055 gives `dout`=0x055, and `unf` stays 1.
- Simultaneous push+pop:
  - With 0x100, 0x200 stacked, push+pop with `din`=0x2AB gives `count`=2 and `dout`=0x2AB. A pop then gives `dout`=0x100.
  - On an empty stack, push+pop with 0x011 gives `count`=1, `dout`=0x011, `unf`=0.
- Reset mid-sequence: push 3 values, then assert `reset` together with `push`=1. After release, `count`=0 and `dout`=0; the next push of 0x123 gives `count`=1.

Source files
------------

// File: rtl/pila_subrutinas.sv
// pila_subrutinas: return-address stack with combinational top-of-stack read and sticky overflow/underflow flags
module pila_subrutinas #(
   parameter int AW    = 10,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [AW-1:0]              din,
   output logic [AW-1:0]              dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf,
   output logic                       unf
);
   localparam int AI = $clog2(DEPTH);
   localparam int PW = AI + 1;
   logic [AW-1:0] mem [DEPTH];
   logic [PW-1:0] sp;
   logic [AI-1:0] top_idx;
   logic [AI-1:0] wr_idx;
   logic          wr_en;
   logic          replace;
   logic          inc;
   logic          dec;
   // pointer decode, write selection and pointer step
   always_comb begin
      top_idx = AI'(sp - PW'(1));
      empty   = (sp == '0);
      full    = (sp == PW'(DEPTH));
      replace = push & pop & !empty;
      wr_en   = push & (pop | !full);
      wr_idx  = replace ? top_idx : sp[AI-1:0];
      inc     = push & !full & (!pop | empty);
      dec     = pop & !push & !empty;
      dout    = empty ? '0 : mem[top_idx];
      count   = sp;
   end
   // stack pointer and sticky error flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp  <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         sp  <= inc ? sp + PW'(1) : dec ? sp - PW'(1) : sp;
         ovf <= ovf | (push & !pop & full);
         unf <= unf | (pop & !push & empty);
      end
   end
   // entry storage, not reset; writes suppressed while reset is held
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[wr_idx] <= din;
   end
endmodule

// File: tb/tb_pila_subrutinas.sv
// tb_pila_subrutinas: directed self-checking bench for the return-address stack
module tb_pila_subrutinas;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [9:0] din = '0;
   logic [9:0] dout;
   logic       empty;
   logic       full;
   logic [3:0] count;
   logic       ovf;
   logic       unf;
   int         n_checks = 0;
   int         n_fail = 0;

   pila_subrutinas #(.AW(10), .DEPTH(8)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
      .dout(dout), .empty(empty), .full(full), .count(count), .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic op(input logic p, input logic q, input logic [9:0] d);
      push = p;
      pop  = q;
      din  = d;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
   endtask

   initial begin
      logic [9:0] lifo [3];
      lifo[0] = 10'h010;
      lifo[1] = 10'h020;
      lifo[2] = 10'h3FF;
      #2;
      reset = 1'b1;
      #1;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_dout", dout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_unf", unf, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) op(1, 0, lifo[i]);
      check("lifo_count", count, 3);
      check("lifo_top", dout, 10'h3FF);
      for (int i = 2; i >= 0; i--) begin
         pop = 1'b1;
         #1;
         check("lifo_pop_dout", dout, lifo[i]);
         op(0, 1, 0);
      end
      check("lifo_empty", empty, 1);
      check("lifo_dout0", dout, 0);
      for (int i = 1; i <= 8; i++) op(1, 0, 10'(i));
      check("full_flag", full, 1);
      check("full_ovf0", ovf, 0);
      op(1, 0, 10'h0AA);
      check("ovf_flag", ovf, 1);
      check("ovf_count", count, 8);
      check("ovf_dout", dout, 10'h008);
      for (int i = 8; i >= 1; i--) begin
         pop = 1'b1;
         #1;
         check("full_pop_dout", dout, i);
         op(0, 1, 0);
      end
      check("full_drained", empty, 1);
      check("ovf_sticky", ovf, 1);
      op(0, 1, 0);
      check("unf_flag", unf, 1);
      check("unf_count", count, 0);
      op(1, 0, 10'h055);
      check("unf_push_dout", dout, 10'h055);
      check("unf_sticky", unf, 1);
      pulse_reset();
      check("rst2_flags", {ovf, unf}, 0);
      op(1, 1, 10'h011);
      check("pp_empty_count", count, 1);
      check("pp_empty_dout", dout, 10'h011);
      check("pp_empty_unf", unf, 0);
      op(0, 1, 0);
      op(1, 0, 10'h100);
      op(1, 0, 10'h200);
      op(1, 1, 10'h2AB);
      check("pp_count", count, 2);
      check("pp_dout", dout, 10'h2AB);
      op(0, 1, 0);
      check("pp_pop_dout", dout, 10'h100);
      check("pp_pop_count", count, 1);
      pulse_reset();
      op(1, 0, 10'h001);
      op(1, 0, 10'h002);
      op(1, 0, 10'h003);
      check("mid_count3", count, 3);
      push  = 1'b1;
      din   = 10'h3AA;
      reset = 1'b1;
      #1;
      check("mid_async_count", count, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      push  = 1'b0;
      #1;
      check("mid_count", count, 0);
      check("mid_dout", dout, 0);
      op(1, 0, 10'h123);
      check("mid_push_count", count, 1);
      check("mid_push_dout", dout, 10'h123);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
